// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage in front of decode. Owns the PC and keeps at most one
// request outstanding to instruction memory over a valid/ready handshake. The
// returned word is registered into the IF/ID pipeline register. Decode can
// stall IF/ID, and a branch/jump from EX can redirect the PC and flush the
// stage.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_valid/ready     fetch request handshake
//   imem_req_addr            fetch address (= PC, word aligned)
//   imem_rsp_valid/data      returned instruction word
//   redirect_valid/pc        taken branch/jump target (low two bits ignored)
//   id_stall                 decode cannot take a new instruction
//   if_id_valid/pc/pc_plus4/instruction   IF/ID pipeline register
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instruction
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // request presented to memory
        S_WAIT  = 2'd1,  // request accepted, awaiting the word
        S_HOLD  = 2'd2,  // word received while decode stalled, parked locally
        S_DRAIN = 2'd3   // request made obsolete by a redirect, discard its word
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic        load_en;
    logic [31:0] load_pc;
    logic [31:0] load_instr;
    logic [31:0] redirect_target;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_pc4_d    = id_pc4_q;
        id_instr_d  = id_instr_q;
        hold_data_d = hold_data_q;
        hold_pc_d   = hold_pc_q;
        load_en     = 1'b0;
        load_pc     = pc_q;
        load_instr  = imem_rsp_data;

        case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    pc_d = pc_q + 32'd4;
                    if (!id_stall) begin
                        load_en = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        // Park the word with its own PC; the PC already moves
                        // on so the next fetch address is ready on release.
                        hold_data_d = imem_rsp_data;
                        hold_pc_d   = pc_q;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!id_stall) begin
                    load_en    = 1'b1;
                    load_pc    = hold_pc_q;
                    load_instr = hold_data_q;
                    state_d    = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (load_en) begin
            id_valid_d = 1'b1;
            id_pc_d    = load_pc;
            id_pc4_d   = load_pc + 32'd4;
            id_instr_d = load_instr;
        end

        // Redirect beats everything, including stall. An accepted request that
        // has not yet returned must be drained so its word never reaches IF/ID.
        if (redirect_valid) begin
            pc_d        = redirect_target;
            id_valid_d  = 1'b0;
            id_pc_d     = id_pc_q;
            id_pc4_d    = id_pc4_q;
            id_instr_d  = NOP_INSTR;
            hold_data_d = 32'd0;
            hold_pc_d   = 32'd0;
            case (state_q)
                S_REQ:   state_d = imem_req_ready ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                S_HOLD:  state_d = S_REQ;
                S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_pc_q     <= 32'd0;
            id_pc4_q    <= 32'd0;
            id_instr_q  <= NOP_INSTR;
            hold_data_q <= 32'd0;
            hold_pc_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_pc4_q    <= id_pc4_d;
            id_instr_q  <= id_instr_d;
            hold_data_q <= hold_data_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    assign imem_req_valid    = (state_q == S_REQ) && !rst;
    assign imem_req_addr     = pc_q;
    assign if_id_valid       = id_valid_q;
    assign if_id_pc          = id_pc_q;
    assign if_id_pc_plus4    = id_pc4_q;
    assign if_id_instruction = id_instr_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. A memory model answers accepted requests
// after a random latency. Every accepted fetch is pushed into a scoreboard;
// a redirect or reset discards everything issued up to that edge. A separate
// monitor pops an entry each time IF/ID presents a new instruction.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_stall = 1'b0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;

    if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .id_stall          (id_stall),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instruction (if_id_instruction)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    fetch_t      sb[$];
    int          checks = 0;
    int          failures = 0;
    int          loads = 0;

    // memory model
    bit          mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;
    int          lat_min = 0;
    int          lat_max = 0;

    logic [31:0] exp_fetch = RESET_PC;
    bit          last_rst = 1'b1;
    bit          last_redirect = 1'b0;
    bit          last_stall = 1'b0;
    bit          last_accept = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // One clock of stimulus plus the reference model's view of that edge.
    task automatic step(input bit r, input bit rdy, input bit st, input bit rv,
                        input logic [31:0] rp);
        logic        req_v;
        logic [31:0] req_a;
        bit          rsp_now;
        bit          was_pending;
        fetch_t      e;
        @(negedge clk);
        rst            = r;
        imem_req_ready = rdy;
        id_stall       = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_rsp_valid = mem_pending && (mem_cnt == 0) && !r;
        imem_rsp_data  = imem_rsp_valid ? word_of(mem_addr) : $urandom;
        #1;
        req_v = imem_req_valid;
        req_a = imem_req_addr;
        if (r) chk("req_valid_in_reset", {31'd0, req_v}, 32'd0);
        @(posedge clk);
        rsp_now       = imem_rsp_valid;
        last_rst      = r;
        last_redirect = rv && !r;
        last_stall    = st;
        last_accept   = 1'b0;
        if (r) begin
            mem_pending = 1'b0;
            sb.delete();
            exp_fetch = RESET_PC;
        end else begin
            was_pending = mem_pending;
            if (rsp_now) mem_pending = 1'b0;
            else if (mem_pending && mem_cnt != 0) mem_cnt--;
            if (req_v && rdy) begin
                last_accept = 1'b1;
                chk("single_outstanding", {31'd0, was_pending}, 32'd0);
                chk("req_addr", req_a, exp_fetch);
                e.pc    = exp_fetch;
                e.instr = word_of(exp_fetch);
                sb.push_back(e);
                exp_fetch   = exp_fetch + 32'd4;
                mem_pending = 1'b1;
                mem_addr    = req_a;
                mem_cnt     = $urandom_range(lat_max, lat_min);
            end
            if (rv) begin
                sb.delete();
                exp_fetch = rp & 32'hFFFF_FFFC;
            end
        end
        #1;
        if (r) begin
            chk("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
            chk("rst_if_id_pc", if_id_pc, 32'd0);
            chk("rst_if_id_pc4", if_id_pc_plus4, 32'd0);
            chk("rst_if_id_instr", if_id_instruction, NOP_INSTR);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic wait_accept();
        int k;
        k = 0;
        do begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            k++;
        end while (!last_accept && k < 20);
        chk("accept_timeout", {31'd0, last_accept}, 32'd1);
    endtask

    // Monitor: compares IF/ID against the scoreboard and the hold/flush rules.
    initial begin : monitor
        logic        prev_valid;
        logic [31:0] prev_pc, prev_pc4, prev_instr;
        fetch_t      e;
        prev_valid = 1'b0;
        prev_pc    = 32'd0;
        prev_pc4   = 32'd0;
        prev_instr = NOP_INSTR;
        forever begin
            @(negedge clk);
            if (!last_rst) begin
                if (last_redirect) begin
                    chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
                    chk("flush_pc_hold", if_id_pc, prev_pc);
                    chk("flush_pc4_hold", if_id_pc_plus4, prev_pc4);
                end else if (last_stall) begin
                    chk("stall_hold_valid", {31'd0, if_id_valid}, {31'd0, prev_valid});
                    chk("stall_hold_pc", if_id_pc, prev_pc);
                    chk("stall_hold_instr", if_id_instruction, prev_instr);
                end else if (if_id_valid && (!prev_valid || if_id_pc != prev_pc
                                             || if_id_instruction != prev_instr)) begin
                    loads++;
                    if (sb.size() == 0) begin
                        chk("unexpected_instr_pc", if_id_pc, 32'hXXXX_XXXX);
                    end else begin
                        e = sb.pop_front();
                        chk("if_id_pc", if_id_pc, e.pc);
                        chk("if_id_instr", if_id_instruction, e.instr);
                        chk("if_id_pc_plus4", if_id_pc_plus4, e.pc + 32'd4);
                    end
                end else begin
                    chk("valid_no_drop", {31'd0, if_id_valid}, {31'd0, prev_valid | if_id_valid});
                end
                if (!if_id_valid) chk("nop_when_invalid", if_id_instruction, NOP_INSTR);
            end
            prev_valid = if_id_valid;
            prev_pc    = if_id_pc;
            prev_pc4   = if_id_pc_plus4;
            prev_instr = if_id_instruction;
        end
    end

    initial begin : stimulus
        int loads0;
        // 1: reset, zero-wait memory, one instruction every two cycles
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        lat_min = 0; lat_max = 0;
        loads0 = loads;
        run(9);
        chk("zero_wait_cadence", loads - loads0, 32'd4);

        // 2: stall while the word for the outstanding fetch arrives
        lat_min = 1; lat_max = 1;
        wait_accept();
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        run(6);

        // 3: redirect while waiting; stale word dropped, refetch at 0x100
        wait_accept();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
        run(8);

        // 4: redirect and stall in the same cycle
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        run(6);

        // 5: PC wrap
        lat_min = 0; lat_max = 0;
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(8);

        // 6: reset while a response is pending
        lat_min = 2; lat_max = 2;
        wait_accept();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        lat_min = 0; lat_max = 2;
        run(8);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(199, 0) == 0),
                 ($urandom_range(3, 0) != 0),
                 ($urandom_range(3, 0) == 0),
                 ($urandom_range(15, 0) == 0),
                 $urandom);
        end

        // quiet tail: fetching must keep flowing
        loads0 = loads;
        run(30);
        chk("tail_progress", {31'd0, (loads - loads0) >= 10}, 32'd1);
        chk("scoreboard_drained", {31'd0, sb.size() <= 1}, 32'd1);
        chk("total_loads", {31'd0, loads >= 200}, 32'd1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
